// File: rtl/mux3_rr_arbiter.sv
// Round-robin owner of a three-source 16-bit mux: registers grant/select and the selected word.
// Optional macro ARB_HOLD_LIMIT_EN forces a release after MAX_HOLD cycles when another requester waits.
module mux3_rr_arbiter #(
    parameter int          WIDTH    = 16,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [2:0]       grant,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid,
    output logic [7:0]       hold_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       select_q, select_d;
    logic [1:0]       last_q, last_d;
    logic [7:0]       hold_q, hold_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;

    logic [1:0]       cand1, cand2, win_idx;
    logic [WIDTH-1:0] src_word;
    logic             req_held;
    logic             force_release;

    // An out-of-range limit leaves an empty marker block; the range is 1..255.
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_out_of_range
    end

    // Search order after the last owner: last+1, last+2, then last itself.
    always_comb begin
        cand1   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        cand2   = (cand1  == 2'd2) ? 2'd0 : cand1 + 2'd1;
        win_idx = last_q;
        if (req[cand1]) begin
            win_idx = cand1;
        end else if (req[cand2]) begin
            win_idx = cand2;
        end
    end

    always_comb begin
        case (select_q)
            2'd0:    src_word = data0;
            2'd1:    src_word = data1;
            default: src_word = data2;
        endcase
    end

    assign req_held = |(req & grant_q);

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [8:0] HOLD_LIMIT = 9'(MAX_HOLD);
    assign force_release = (({1'b0, hold_q} + 9'd1) >= HOLD_LIMIT) && (|(req & ~grant_q));
`else
    assign force_release = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        last_d   = last_q;
        hold_d   = hold_q;
        bus_d    = bus_q;
        valid_d  = (state_q == ST_BUSY);
        // The word is captured only while a grant is live, so it lingers after release.
        if (state_q == ST_BUSY) begin
            bus_d = src_word;
        end
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d  = 3'b001 << win_idx;
                    select_d = win_idx;
                    hold_d   = 8'd0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!req_held || force_release) begin
                    grant_d = 3'b000;
                    last_d  = select_q;
                    hold_d  = 8'd0;
                    state_d = ST_IDLE;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= 3'b000;
            select_q <= 2'd0;
            last_q   <= 2'd2;
            hold_q   <= 8'd0;
            bus_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            bus_q    <= bus_d;
            valid_q  <= valid_d;
        end
    end

    assign grant     = grant_q;
    assign select    = select_q;
    assign bus_out   = bus_q;
    assign bus_valid = valid_q;
    assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Bench for mux3_rr_arbiter: directed vector table, hand sequences, then random traffic against a model.
module tb_mux3_rr_arbiter;

    localparam int MAX_H = 4;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [15:0] data0, data1, data2;
    logic [2:0]  grant;
    logic [1:0]  select;
    logic [15:0] bus_out;
    logic        bus_valid;
    logic [7:0]  hold_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level reference: who owns the bus, who owned it last, how long.
    int          m_owner;
    int          m_last;
    int          m_hold;
    logic [1:0]  m_sel;
    logic [15:0] m_bus;
    logic        m_valid;

    typedef struct {
        logic        rst_n;
        logic [2:0]  req;
        logic [15:0] d0, d1, d2;
        logic [2:0]  grant;
        logic [1:0]  sel;
        logic        valid;
        logic [15:0] bus;
        logic [7:0]  hold;
    } vec_t;

    vec_t vecs[$];

    mux3_rr_arbiter #(.WIDTH(16), .MAX_HOLD(MAX_H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .grant     (grant),
        .select    (select),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .hold_cnt  (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic check_all(input string tag, input logic [2:0] eg, input logic [1:0] es,
                             input logic ev, input logic [15:0] eb, input logic [7:0] eh);
        cmp({tag, ".grant"},     32'(grant),     32'(eg));
        cmp({tag, ".select"},    32'(select),    32'(es));
        cmp({tag, ".bus_valid"}, 32'(bus_valid), 32'(ev));
        cmp({tag, ".bus_out"},   32'(bus_out),   32'(eb));
        cmp({tag, ".hold_cnt"},  32'(hold_cnt),  32'(eh));
    endtask

    task automatic model_step();
        logic [15:0] words [3];
        logic        was_busy;
        logic        limit_hit;
        words = '{data0, data1, data2};
        if (!rst_n) begin
            m_owner = -1; m_last = 2; m_hold = 0;
            m_sel = 2'd0; m_bus = 16'h0; m_valid = 1'b0;
        end else begin
            was_busy = (m_owner >= 0);
            if (was_busy) m_bus = words[m_sel];
            if (!was_busy) begin
                for (int k = 1; k <= 3; k++) begin
                    if (m_owner < 0 && req[(m_last + k) % 3]) begin
                        m_owner = (m_last + k) % 3;
                        m_sel   = 2'(m_owner);
                        m_hold  = 0;
                    end
                end
            end else begin
                limit_hit = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
                limit_hit = (m_hold + 1 >= MAX_H) && ((req & ~(3'b001 << m_owner)) != 3'b000);
`endif
                if (!req[m_owner] || limit_hit) begin
                    m_last = m_owner; m_owner = -1; m_hold = 0;
                end else if (m_hold < 255) begin
                    m_hold = m_hold + 1;
                end
            end
            m_valid = was_busy;
        end
    endtask

    task automatic step(input logic r, input logic [2:0] q,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        @(negedge clk);
        rst_n = r; req = q; data0 = a; data1 = b; data2 = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic void addv(input logic r, input logic [2:0] q, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] c, input logic [2:0] g,
                                 input logic [1:0] s, input logic v, input logic [15:0] w,
                                 input logic [7:0] h);
        vec_t t;
        t.rst_n = r; t.req = q; t.d0 = a; t.d1 = b; t.d2 = c;
        t.grant = g; t.sel = s; t.valid = v; t.bus = w; t.hold = h;
        vecs.push_back(t);
    endfunction

    initial begin
        int prev_owner;
        int cyc;
        logic [2:0] rq;

        rst_n = 1'b0; req = 3'b000; data0 = '0; data1 = '0; data2 = '0;

        // Single requester, four cycles, then release.
        addv(0, 3'b000, 16'hA5A5, 16'h0, 16'h0, 3'b000, 2'd0, 0, 16'h0000, 8'd0);
        addv(1, 3'b001, 16'hA5A5, 16'h0, 16'h0, 3'b001, 2'd0, 0, 16'h0000, 8'd0);
        addv(1, 3'b001, 16'hA5A5, 16'h0, 16'h0, 3'b001, 2'd0, 1, 16'hA5A5, 8'd1);
        addv(1, 3'b001, 16'hA5A5, 16'h0, 16'h0, 3'b001, 2'd0, 1, 16'hA5A5, 8'd2);
        addv(1, 3'b001, 16'hA5A5, 16'h0, 16'h0, 3'b001, 2'd0, 1, 16'hA5A5, 8'd3);
        addv(1, 3'b000, 16'hA5A5, 16'h0, 16'h0, 3'b000, 2'd0, 1, 16'hA5A5, 8'd0);
        addv(1, 3'b000, 16'hA5A5, 16'h0, 16'h0, 3'b000, 2'd0, 0, 16'hA5A5, 8'd0);
        // All three requesting: rotation 0,1,2,0 with an idle cycle between grants.
        addv(0, 3'b000, 16'h1000, 16'h2001, 16'h3002, 3'b000, 2'd0, 0, 16'h0000, 8'd0);
        addv(1, 3'b111, 16'h1000, 16'h2001, 16'h3002, 3'b001, 2'd0, 0, 16'h0000, 8'd0);
        addv(1, 3'b111, 16'h1000, 16'h2001, 16'h3002, 3'b001, 2'd0, 1, 16'h1000, 8'd1);
        addv(1, 3'b110, 16'h1000, 16'h2001, 16'h3002, 3'b000, 2'd0, 1, 16'h1000, 8'd0);
        addv(1, 3'b110, 16'h1000, 16'h2001, 16'h3002, 3'b010, 2'd1, 0, 16'h1000, 8'd0);
        addv(1, 3'b110, 16'h1000, 16'h2001, 16'h3002, 3'b010, 2'd1, 1, 16'h2001, 8'd1);
        addv(1, 3'b100, 16'h1000, 16'h2001, 16'h3002, 3'b000, 2'd1, 1, 16'h2001, 8'd0);
        addv(1, 3'b100, 16'h1000, 16'h2001, 16'h3002, 3'b100, 2'd2, 0, 16'h2001, 8'd0);
        addv(1, 3'b100, 16'h1000, 16'h2001, 16'h3002, 3'b100, 2'd2, 1, 16'h3002, 8'd1);
        addv(1, 3'b001, 16'h1000, 16'h2001, 16'h3002, 3'b000, 2'd2, 1, 16'h3002, 8'd0);
        addv(1, 3'b001, 16'h1000, 16'h2001, 16'h3002, 3'b001, 2'd0, 0, 16'h3002, 8'd0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].d2);
            $display("vec[%0d] req=%b grant=%b select=%0d valid=%b bus=%h hold=%0d",
                     i, req, grant, select, bus_valid, bus_out, hold_cnt);
            check_all($sformatf("vec[%0d]", i), vecs[i].grant, vecs[i].sel,
                      vecs[i].valid, vecs[i].bus, vecs[i].hold);
        end

        // After requester 1 finishes, simultaneous 0 and 2: 2 wins, then 0.
        step(0, 3'b000, 16'h0, 16'h0, 16'h0);
        step(1, 3'b010, 16'h0, 16'h0, 16'h0);
        cmp("rot.grant1", 32'(grant), 32'(3'b010));
        step(1, 3'b010, 16'h0, 16'h0, 16'h0);
        step(1, 3'b000, 16'h0, 16'h0, 16'h0);
        step(1, 3'b101, 16'h0, 16'h0, 16'h0);
        cmp("rot.grant2", 32'(grant), 32'(3'b100));
        cmp("rot.select2", 32'(select), 32'(2'd2));
        step(1, 3'b101, 16'h0, 16'h0, 16'h0);
        step(1, 3'b001, 16'h0, 16'h0, 16'h0);
        cmp("rot.gap", 32'(grant), 32'(3'b000));
        step(1, 3'b001, 16'h0, 16'h0, 16'h0);
        cmp("rot.grant0", 32'(grant), 32'(3'b001));
        $display("rotation sequence done: grant=%b", grant);

        // Reset while requester 1 is mid-transfer.
        step(0, 3'b000, 16'h0, 16'h0, 16'h0);
        step(1, 3'b010, 16'h0, 16'hBEEF, 16'h0);
        step(1, 3'b010, 16'h0, 16'hBEEF, 16'h0);
        cmp("rst.pre_valid", 32'(bus_valid), 32'(1'b1));
        step(0, 3'b010, 16'h0, 16'hBEEF, 16'h0);
        check_all("rst.mid", 3'b000, 2'd0, 1'b0, 16'h0000, 8'd0);
        step(1, 3'b011, 16'h0, 16'hBEEF, 16'h0);
        cmp("rst.regrant", 32'(grant), 32'(3'b001));
        $display("mid-transfer reset done: grant=%b", grant);

        // Long hold by requester 0 with requester 1 waiting.
        step(0, 3'b000, 16'h0, 16'h0, 16'h0);
        step(1, 3'b001, 16'h0, 16'h0, 16'h0);
        cmp("hold.g1", 32'(hold_cnt), 32'd0);
        step(1, 3'b001, 16'h0, 16'h0, 16'h0);
        step(1, 3'b011, 16'h0, 16'h0, 16'h0);
        step(1, 3'b011, 16'h0, 16'h0, 16'h0);
        cmp("hold.cnt3", 32'(hold_cnt), 32'd3);
        step(1, 3'b011, 16'h0, 16'h0, 16'h0);
`ifdef ARB_HOLD_LIMIT_EN
        cmp("hold.forced", 32'(grant), 32'(3'b000));
        step(1, 3'b011, 16'h0, 16'h0, 16'h0);
        cmp("hold.next", 32'(grant), 32'(3'b010));
        cmp("hold.next_sel", 32'(select), 32'(2'd1));
`else
        cmp("hold.kept", 32'(grant), 32'(3'b001));
        cmp("hold.cnt4", 32'(hold_cnt), 32'd4);
        for (int i = 0; i < 260; i++) step(1, 3'b011, 16'h0, 16'h0, 16'h0);
        cmp("hold.sat", 32'(hold_cnt), 32'd255);
        cmp("hold.still", 32'(grant), 32'(3'b001));
`endif
        $display("hold sequence done: grant=%b hold=%0d", grant, hold_cnt);

        // Random traffic against the model.
        step(0, 3'b000, 16'h0, 16'h0, 16'h0);
        rq = 3'b000;
        for (cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < 3; b++) begin
                if (rq[b]) begin
                    if ($urandom_range(0, 5) == 0) rq[b] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    rq[b] = 1'b1;
                end
            end
            prev_owner = m_owner;
            step(($urandom_range(0, 99) != 0), rq, 16'($urandom), 16'($urandom), 16'($urandom));
            if (m_owner >= 0 && prev_owner < 0)
                $display("rand cycle %0d: grant to %0d (req=%b)", cyc, m_owner, rq);
            check_all($sformatf("rand[%0d]", cyc),
                      (m_owner < 0) ? 3'b000 : 3'(3'b001 << m_owner),
                      m_sel, m_valid, m_bus, 8'(m_hold));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
